// File: rtl/logic_unit_arbiter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// logic_unit_arbiter
//
// Shares one 4-bit logicUnit (AND/OR/XOR with one-hot opCode gating) between
// two requesters. A command is accepted in IDLE, its operands are presented to
// the logicUnit for exactly one EXEC cycle with the matching one-hot opcode,
// and the OR of the three unit results is captured and offered on a
// valid/ready response port.
//
// Parameters
//   WIDTH       operand/result width, must match the logicUnit (4)
//   PRIO_FIXED  0 = round-robin on ties, 1 = requester 0 always wins ties
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid/ready               command handshake for requester N (0/1)
//   reqN_op                        0=AND 1=OR 2=XOR 3=illegal
//   reqN_a, reqN_b                 operands
//   lu_opcode                      one-hot opCode to the logicUnit
//   lu_a, lu_b                     operands to the logicUnit
//   lu_res_and/or/xor              logicUnit results
//   rsp_valid/ready                response handshake
//   rsp_id                         index of the requester being answered
//   rsp_data                       bitwise result
//   rsp_err                        illegal op flag (rsp_data is 0)
// ----------------------------------------------------------------------------
module logic_unit_arbiter #(
  parameter int WIDTH      = 4,
  parameter int PRIO_FIXED = 0
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic [2:0]       lu_opcode,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  input  logic [WIDTH-1:0] lu_res_and,
  input  logic [WIDTH-1:0] lu_res_or,
  input  logic [WIDTH-1:0] lu_res_xor,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  // Decode of a command op into the logicUnit's one-hot opCode; the illegal
  // op leaves every unit output gated off.
  function automatic logic [2:0] f_onehot(input logic [1:0] op);
    logic [2:0] oh;
    case (op)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Only the selected unit output is non-zero, so OR-ing all three yields the
  // result. An illegal op is forced to zero regardless of what the unit does.
  function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] res_and,
                                               input logic [WIDTH-1:0] res_or,
                                               input logic [WIDTH-1:0] res_xor,
                                               input logic             illegal);
    return illegal ? '0 : (res_and | res_or | res_xor);
  endfunction

  state_t           r_state;
  logic             r_rr_ptr;
  logic [1:0]       r_op;
  logic             r_id;
  logic [2:0]       r_lu_opcode;
  logic [WIDTH-1:0] r_lu_a;
  logic [WIDTH-1:0] r_lu_b;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;

  logic             w_idle;
  logic             w_fav0;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_take;
  logic [1:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  // Arbitration: requester 0 wins a tie when the pointer favours it (or
  // always, with fixed priority); a lone requester is always granted.
  always_comb begin
    w_idle   = (r_state == S_IDLE);
    w_fav0   = (PRIO_FIXED != 0) | ~r_rr_ptr;
    w_grant0 = req0_valid & (~req1_valid | w_fav0);
    w_grant1 = req1_valid & ~w_grant0;
    w_take   = w_grant0 | w_grant1;
    w_sel_op = w_grant0 ? req0_op : req1_op;
    w_sel_a  = w_grant0 ? req0_a  : req1_a;
    w_sel_b  = w_grant0 ? req0_b  : req1_b;
  end

  assign req0_ready = w_idle & w_grant0;
  assign req1_ready = w_idle & w_grant1;

  assign lu_opcode  = r_lu_opcode;
  assign lu_a       = r_lu_a;
  assign lu_b       = r_lu_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;

  // Command context kept for the EXEC/RESP phases; it needs no reset because
  // it is only consumed after a fresh acceptance.
  always_ff @(posedge clk) begin
    if (!rst && w_idle && w_take) begin
      r_op <= w_sel_op;
      r_id <= w_grant1;
    end
  end

  // Control FSM with registered logicUnit drive and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 1'b0;
      r_lu_opcode <= 3'b000;
      r_lu_a      <= '0;
      r_lu_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        // Accept: operands go straight to the unit ports so they are
        // present for the whole EXEC cycle and then simply held.
        S_IDLE: begin
          if (w_take) begin
            r_lu_a      <= w_sel_a;
            r_lu_b      <= w_sel_b;
            r_lu_opcode <= f_onehot(w_sel_op);
            r_state     <= S_EXEC;
          end
        end
        // Execute: the unit is combinational, its outputs are captured here
        // and the opcode is dropped so the unit idles at zero afterwards.
        S_EXEC: begin
          r_rsp_data  <= f_merge(lu_res_and, lu_res_or, lu_res_xor,
                                 r_op == OP_ILLEGAL);
          r_rsp_err   <= (r_op == OP_ILLEGAL);
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_lu_opcode <= 3'b000;
          r_state     <= S_RESP;
        end
        // Respond: hold everything until the consumer takes it; the next tie
        // then favours the requester that was not just served.
        S_RESP: begin
          if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (PRIO_FIXED == 0) begin
              r_rr_ptr <= ~r_rsp_id;
            end
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
